// File: rtl/bus_arbiter_2to1.sv
// Round-robin two-master arbiter for a single bus slave. A granted master keeps the
// slave while it stalls, and a sticky watchdog flags stalls that run too long.
module bus_arbiter_2to1 #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MASK_W         = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_data_wr,
    input  logic [MASK_W-1:0] m0_mask,
    output logic              m0_stall,
    output logic [DATA_W-1:0] m0_data_rd,
    output logic [DATA_W-1:0] m0_data_rd_2,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_data_wr,
    input  logic [MASK_W-1:0] m1_mask,
    output logic              m1_stall,
    output logic [DATA_W-1:0] m1_data_rd,
    output logic [DATA_W-1:0] m1_data_rd_2,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_data_wr,
    output logic [MASK_W-1:0] s_mask,
    input  logic              s_stall,
    input  logic [DATA_W-1:0] s_data_rd,
    input  logic [DATA_W-1:0] s_data_rd_2,

    output logic              bus_timeout,
    output logic              grant_owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_t      state;
    state_t      state_next;
    logic        last;
    logic        last_next;
    logic [15:0] hold_cnt;
    logic [15:0] hold_cnt_next;
    logic        req0;
    logic        req1;
    logic        gnt_valid;
    logic        gnt_idx;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // While reset is held nobody is granted, so the slave sees no strobes.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    gnt_valid = req0 | req1;
                    gnt_idx   = (req0 && req1) ? ~last : req1;
                end
                OWN0: begin
                    gnt_valid = 1'b1;
                    gnt_idx   = 1'b0;
                end
                OWN1: begin
                    gnt_valid = 1'b1;
                    gnt_idx   = 1'b1;
                end
                default: begin
                    gnt_valid = 1'b0;
                    gnt_idx   = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    if (s_stall) begin
                        state_next = gnt_idx ? OWN1 : OWN0;
                    end else begin
                        last_next = gnt_idx;
                    end
                end
            end
            OWN0: begin
                if (!s_stall || !req0) begin
                    state_next = IDLE;
                    last_next  = 1'b0;
                end
            end
            OWN1: begin
                if (!s_stall || !req1) begin
                    state_next = IDLE;
                    last_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Only stall cycles that keep the lock count toward the watchdog limit.
    always_comb begin
        hold_cnt_next = hold_cnt;
        if (state_next == IDLE) begin
            hold_cnt_next = 16'd0;
        end else if (state != IDLE && s_stall && hold_cnt < TIMEOUT_LIM) begin
            hold_cnt_next = hold_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            hold_cnt    <= 16'd0;
            bus_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            last        <= last_next;
            hold_cnt    <= hold_cnt_next;
            bus_timeout <= bus_timeout | (hold_cnt_next == TIMEOUT_LIM);
        end
    end

    assign busy        = (state != IDLE);
    assign grant_owner = (state == OWN1);

    always_comb begin
        s_address    = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_data_wr    = '0;
        s_mask       = '0;
        m0_stall     = req0;
        m0_data_rd   = '0;
        m0_data_rd_2 = '0;
        m1_stall     = req1;
        m1_data_rd   = '0;
        m1_data_rd_2 = '0;
        if (gnt_valid) begin
            if (!gnt_idx) begin
                s_address    = m0_address;
                s_read       = m0_read;
                s_write      = m0_write;
                s_data_wr    = m0_data_wr;
                s_mask       = m0_mask;
                m0_stall     = s_stall;
                m0_data_rd   = s_data_rd;
                m0_data_rd_2 = s_data_rd_2;
            end else begin
                s_address    = m1_address;
                s_read       = m1_read;
                s_write      = m1_write;
                s_data_wr    = m1_data_wr;
                s_mask       = m1_mask;
                m1_stall     = s_stall;
                m1_data_rd   = s_data_rd;
                m1_data_rd_2 = s_data_rd_2;
            end
        end
    end

endmodule
